memory: RTL and testbench
=========================

// Module: memory
// PURPOSE
// - MEM stage of the 19-bit pipelined processor plus the MEM/WB pipeline register.
// - Holds a byte-addressable data RAM; performs byte or word loads/stores at ALUResultM.
// - Forwards the writeback control and destination register to the W stage.
// - Produces the final writeback value ResultW.
// PARAMETERS
// - DEPTH       1024  data RAM size in bytes; power of two
// - ADDR_W      10    $clog2(DEPTH); low ADDR_W bits of ALUResultM index the RAM
// PORTS
// - clk          in   1   single clock; all state updates on rising edge
// - reset        in   1   asynchronous, active-high reset
// - RegWriteM    in   1   register-file write enable (M stage)
// - MemWriteM    in   1   data RAM store enable
// - ResultSrcM   in   1   writeback select: 0=ALU result, 1=load data
// - RDM          in   5   destination register index
// - WriteDataM   in   19  store data
// - ALUResultM   in   19  effective byte address / ALU result
// - Cant_ByteM   in   1   access size: 0=1 byte, 1=full word (3 bytes)
// - RegWriteW    out  1   registered RegWriteM
// - ResultSrcW   out  1   registered ResultSrcM
// - RDW          out  5   registered RDM
// - ReadDataW    out  19  registered load data
// - ResultW      out  19  ResultSrcW ? ReadDataW : ALUResultW (combinational)
// BEHAVIOUR
// - Reset (async, active-high): RegWriteW, ResultSrcW, RDW, ReadDataW and the internal ALUResultW clear to 0.
// - During reset, ResultW = 0. RAM contents are not reset; the RAM is zero-initialised at time 0.
// - Store: on the rising edge with MemWriteM=1 and reset=0:
//   - byte: mem[a] <= WriteDataM[7:0]
//   - word: mem[a] <= [7:0], mem[a+1] <= [15:8], mem[a+2] <= {5'b0, [18:16]} (little-endian)
// - Load data is read combinationally from a = ALUResultM[ADDR_W-1:0]:
//   - byte: {11'b0, mem[a]} (zero-extended)
//   - word: {mem[a+2][2:0], mem[a+1], mem[a]}
// - The combinational load value is captured into ReadDataW on the rising edge, giving 1-cycle load latency.
// - Load data is captured every cycle regardless of MemWriteM/ResultSrcM.
// - Same-edge read and write to the same address: ReadDataW gets the OLD contents; the next cycle's read sees the new data.
// - Byte addresses a+1 and a+2 wrap modulo DEPTH.
// - With MEM_ADDR_CHECK_EN undefined, ALUResultM bits above ADDR_W are ignored (aliasing).
// - The pipeline register copies RegWriteM, ResultSrcM, RDM and ALUResultM every edge; there is no stall or flush input.
// - A reset asserted mid-operation aborts any store on that edge and clears the W outputs immediately.
// CONFIGURATION
// - MEM_ADDR_CHECK_EN defined: an access is out of range if ALUResultM >= DEPTH, or if a word access has ALUResultM > DEPTH-3.
//   - Out-of-range stores are dropped (RAM unchanged).
//   - Out-of-range loads return 0 into ReadDataW.
//   - No wrap-around occurs.
// - MEM_ADDR_CHECK_EN undefined: modulo addressing as above; no range checks.
// STRUCTURE
// - memory_pkg holds:
//   - XLEN=19, REG_IDX_W=5
//   - ACC_BYTE=1'b0, ACC_WORD=1'b1
//   - RES_ALU=1'b0, RES_MEM=1'b1
// - Sub-module data_ram: byte array with a synchronous byte/word write port and an asynchronous byte/word read port.
// - Top level holds data_ram, the MEM/WB register (including the ALUResultW register) and the ResultW mux.
// TESTING
// - Reset: assert reset mid-cycle -> all W outputs read 0 immediately, without waiting for a clock edge.
// - Byte store then load:
//   - MemWriteM=1, WriteDataM=0x3, ALUResultM=0x5, Cant_ByteM=0 for 4 cycles.
//   - Then MemWriteM=0, ALUResultM=0x5 -> ReadDataW=0x00003 one edge later.
//   - With ResultSrcM=1 -> ResultW=0x00003.
// - Word store/load: store 0x7ABCD to address 0x10 with Cant_ByteM=1.
//   - Load as word -> 0x7ABCD.
//   - Byte load of 0x12 -> 0x00007.
// - Byte-store isolation: after the word at 0x10, byte-store 0xFF to 0x11 -> word load at 0x10 returns 0x7FFCD.
// - Read-during-write: store 0x55 to 0x20 while reading 0x20 -> ReadDataW shows the old value; the next cycle shows 0x00055.
// - Pass-through: RegWriteM=1, RDM=5'd9, ResultSrcM=0, ALUResultM=0x12345 -> next edge RegWriteW=1, RDW=9, ResultW=0x12345.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared widths, access-size/writeback encodings and byte-packing helpers
// for the MEM stage of the 19-bit pipeline.
package memory_pkg;

    localparam int XLEN      = 19;
    localparam int REG_IDX_W = 5;

    localparam logic ACC_BYTE = 1'b0;
    localparam logic ACC_WORD = 1'b1;

    localparam logic RES_ALU = 1'b0;
    localparam logic RES_MEM = 1'b1;

    // A 19-bit word spans three bytes; only the low 3 bits of the top byte are meaningful.
    function automatic logic [XLEN-1:0] packWord(
        input logic [7:0] byte0,
        input logic [7:0] byte1,
        input logic [7:0] byte2
    );
        return {byte2[2:0], byte1, byte0};
    endfunction

    function automatic logic [XLEN-1:0] zextByte(input logic [7:0] byte0);
        return {11'b0, byte0};
    endfunction

endpackage

// File: rtl/memory_data_ram.sv
// Byte-addressable data RAM: synchronous byte/word write, asynchronous byte/word
// read, little-endian, with neighbouring byte addresses wrapping modulo DEPTH.
module data_ram
    import memory_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wrEn,
    input  logic              accSize,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wrData,
    output logic [XLEN-1:0]   rdData
);

    // Contents are never reset; they start out as zero.
    logic [7:0] memArray_r [DEPTH] = '{default: 8'h00};

    logic [ADDR_W-1:0] addr1_s;
    logic [ADDR_W-1:0] addr2_s;

    assign addr1_s = addr + ADDR_W'(1);
    assign addr2_s = addr + ADDR_W'(2);

    // Write port: low byte always, upper two bytes only for word stores.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            memArray_r[addr] <= wrData[7:0];
            if (accSize == ACC_WORD) begin
                memArray_r[addr1_s] <= wrData[15:8];
                memArray_r[addr2_s] <= {5'b0, wrData[18:16]};
            end
        end
    end

    // Read port: combinational, so a same-edge write is seen only next cycle.
    always_comb begin
        case (accSize)
            ACC_WORD: rdData = packWord(memArray_r[addr], memArray_r[addr1_s], memArray_r[addr2_s]);
            ACC_BYTE: rdData = zextByte(memArray_r[addr]);
            default:  rdData = zextByte(memArray_r[addr]);
        endcase
    end

endmodule

// File: rtl/memory.sv
// MEM stage plus MEM/WB pipeline register and writeback mux.
// Build option MEM_ADDR_CHECK_EN: drop out-of-range stores and zero out-of-range loads.
module memory
    import memory_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RegWriteM,
    input  logic                 MemWriteM,
    input  logic                 ResultSrcM,
    input  logic [REG_IDX_W-1:0] RDM,
    input  logic [XLEN-1:0]      WriteDataM,
    input  logic [XLEN-1:0]      ALUResultM,
    input  logic                 Cant_ByteM,
    output logic                 RegWriteW,
    output logic                 ResultSrcW,
    output logic [REG_IDX_W-1:0] RDW,
    output logic [XLEN-1:0]      ReadDataW,
    output logic [XLEN-1:0]      ResultW
);

    logic              accessOk_s;
    logic              wrEn_s;
    logic [ADDR_W-1:0] ramAddr_s;
    logic [XLEN-1:0]   ramRdData_s;
    logic [XLEN-1:0]   loadData_s;
    logic [XLEN-1:0]   aluResultW_r;

`ifdef MEM_ADDR_CHECK_EN
    localparam logic [XLEN-1:0] DEPTH_X     = XLEN'(DEPTH);
    localparam logic [XLEN-1:0] LAST_WORD_X = XLEN'(DEPTH - 3);

    // Range check on the full address; a word must fit without wrapping.
    always_comb begin
        if (ALUResultM >= DEPTH_X) begin
            accessOk_s = 1'b0;
        end else if ((Cant_ByteM == ACC_WORD) && (ALUResultM > LAST_WORD_X)) begin
            accessOk_s = 1'b0;
        end else begin
            accessOk_s = 1'b1;
        end
    end
`else
    assign accessOk_s = 1'b1;
`endif

    // Reset on the same edge aborts the store.
    assign wrEn_s    = MemWriteM & accessOk_s & ~reset;
    assign ramAddr_s = ALUResultM[ADDR_W-1:0];

    data_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dataRam (
        .clk     (clk),
        .wrEn    (wrEn_s),
        .accSize (Cant_ByteM),
        .addr    (ramAddr_s),
        .wrData  (WriteDataM),
        .rdData  (ramRdData_s)
    );

    // Out-of-range loads return zero; always accepted otherwise.
    always_comb begin
        if (accessOk_s) begin
            loadData_s = ramRdData_s;
        end else begin
            loadData_s = {XLEN{1'b0}};
        end
    end

    // MEM/WB register: free-running, no stall or flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWriteW    <= 1'b0;
            ResultSrcW   <= 1'b0;
            RDW          <= {REG_IDX_W{1'b0}};
            ReadDataW    <= {XLEN{1'b0}};
            aluResultW_r <= {XLEN{1'b0}};
        end else begin
            RegWriteW    <= RegWriteM;
            ResultSrcW   <= ResultSrcM;
            RDW          <= RDM;
            ReadDataW    <= loadData_s;
            aluResultW_r <= ALUResultM;
        end
    end

    // Writeback select.
    always_comb begin
        case (ResultSrcW)
            RES_MEM: ResultW = ReadDataW;
            RES_ALU: ResultW = aluResultW_r;
            default: ResultW = aluResultW_r;
        endcase
    end

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for the MEM stage: directed scenarios plus randomized
// traffic compared against a byte-array reference model.
module tb_memory;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteM, MemWriteM, ResultSrcM, Cant_ByteM;
    logic [4:0]  RDM;
    logic [18:0] WriteDataM, ALUResultM;
    logic        RegWriteW, ResultSrcW;
    logic [4:0]  RDW;
    logic [18:0] ReadDataW, ResultW;

    int vectors = 0;
    int miscompares = 0;

    // Reference state
    logic [7:0]  refMem [DEPTH];
    logic        expRegW, expSrcW;
    logic [4:0]  expRdW;
    logic [18:0] expReadW, expAluW, expResultW;

    always #5 clk = ~clk;

    memory dut (
        .clk        (clk),
        .reset      (reset),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .RDM        (RDM),
        .WriteDataM (WriteDataM),
        .ALUResultM (ALUResultM),
        .Cant_ByteM (Cant_ByteM),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .RDW        (RDW),
        .ReadDataW  (ReadDataW),
        .ResultW    (ResultW)
    );

    function automatic bit inRange(input logic [18:0] addr, input logic word);
`ifdef MEM_ADDR_CHECK_EN
        int unsigned a = addr;
        if (a >= DEPTH) return 1'b0;
        if (word && a > DEPTH - 3) return 1'b0;
        return 1'b1;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [18:0] refLoad(input logic [18:0] addr, input logic word);
        int unsigned a = addr % DEPTH;
        int unsigned val;
        if (!inRange(addr, word)) return 19'd0;
        if (!word) return {11'd0, refMem[a]};
        val = refMem[a] + 256 * refMem[(a + 1) % DEPTH] + 65536 * (refMem[(a + 2) % DEPTH] % 8);
        return val[18:0];
    endfunction

    task automatic refStore(input logic [18:0] addr, input logic word, input logic [18:0] data);
        int unsigned a = addr % DEPTH;
        int unsigned d = data;
        if (!inRange(addr, word)) return;
        refMem[a] = d[7:0];
        if (word) begin
            refMem[(a + 1) % DEPTH] = 8'((d / 256) % 256);
            refMem[(a + 2) % DEPTH] = 8'(d / 65536);
        end
    endtask

    task automatic drive(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                         input logic [18:0] wd, input logic [18:0] alu, input logic cb);
        RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RDM = rd;
        WriteDataM = wd; ALUResultM = alu; Cant_ByteM = cb;
    endtask

    // One rising edge: update the model from the inputs held across it, then settle.
    task automatic applyEdge();
        @(posedge clk);
        if (!reset) begin
            expReadW = refLoad(ALUResultM, Cant_ByteM);
            if (MemWriteM) refStore(ALUResultM, Cant_ByteM, WriteDataM);
            expRegW = RegWriteM; expSrcW = ResultSrcM; expRdW = RDM; expAluW = ALUResultM;
        end
        expResultW = expSrcW ? expReadW : expAluW;
        #1;
    endtask

    task automatic clearModelRegs();
        expRegW = 1'b0; expSrcW = 1'b0; expRdW = 5'd0; expReadW = 19'd0; expAluW = 19'd0;
        expResultW = 19'd0;
    endtask

    task automatic test_reset();
        // Power-on reset, checked before any clock edge.
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 19'd0, 19'd0, 1'b0);
        #3;
        vectors++;
        if ({RegWriteW, ResultSrcW, RDW, ReadDataW, ResultW} !== 45'd0) begin
            miscompares++;
            $display("FAIL reset_por outputs=%h expected 0", {RegWriteW, ResultSrcW, RDW, ReadDataW, ResultW});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        // Make W outputs nonzero, then assert reset mid-cycle.
        drive(1'b1, 1'b0, 1'b0, 5'd17, 19'd0, 19'h2AAAA, 1'b0);
        applyEdge();
        vectors++;
        if (RDW !== 5'd17 || ResultW !== 19'h2AAAA) begin
            miscompares++;
            $display("FAIL reset_pre RDW=%0d ResultW=%h expected 17 2aaaa", RDW, ResultW);
        end
        #2;
        reset = 1'b1;
        #1;
        clearModelRegs();
        vectors++;
        if ({RegWriteW, ResultSrcW, RDW, ReadDataW, ResultW} !== 45'd0) begin
            miscompares++;
            $display("FAIL reset_async outputs=%h expected 0", {RegWriteW, ResultSrcW, RDW, ReadDataW, ResultW});
        end
        // A store attempted under reset must be dropped.
        drive(1'b0, 1'b1, 1'b0, 5'd0, 19'h000AA, 19'h30, 1'b0);
        applyEdge();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 5'd0, 19'd0, 19'h30, 1'b0);
        applyEdge();
        vectors++;
        if (ReadDataW !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_store_abort ReadDataW=%h expected 0", ReadDataW);
        end
    endtask

    task automatic test_byte_store_load();
        drive(1'b0, 1'b1, 1'b0, 5'd0, 19'h3, 19'h5, 1'b0);
        repeat (4) applyEdge();
        drive(1'b0, 1'b0, 1'b1, 5'd0, 19'd0, 19'h5, 1'b0);
        applyEdge();
        vectors++;
        if (ReadDataW !== 19'h00003) begin
            miscompares++;
            $display("FAIL byte_load ReadDataW=%h expected 00003", ReadDataW);
        end
        vectors++;
        if (ResultW !== 19'h00003) begin
            miscompares++;
            $display("FAIL byte_load_result ResultW=%h expected 00003", ResultW);
        end
    endtask

    task automatic test_word_store_load();
        drive(1'b0, 1'b1, 1'b0, 5'd0, 19'h7ABCD, 19'h10, 1'b1);
        applyEdge();
        drive(1'b0, 1'b0, 1'b1, 5'd0, 19'd0, 19'h10, 1'b1);
        applyEdge();
        vectors++;
        if (ReadDataW !== 19'h7ABCD) begin
            miscompares++;
            $display("FAIL word_load ReadDataW=%h expected 7abcd", ReadDataW);
        end
        drive(1'b0, 1'b0, 1'b1, 5'd0, 19'd0, 19'h12, 1'b0);
        applyEdge();
        vectors++;
        if (ReadDataW !== 19'h00007) begin
            miscompares++;
            $display("FAIL word_top_byte ReadDataW=%h expected 00007", ReadDataW);
        end
    endtask

    task automatic test_byte_isolation();
        drive(1'b0, 1'b1, 1'b0, 5'd0, 19'h000FF, 19'h11, 1'b0);
        applyEdge();
        drive(1'b0, 1'b0, 1'b1, 5'd0, 19'd0, 19'h10, 1'b1);
        applyEdge();
        vectors++;
        if (ReadDataW !== 19'h7FFCD) begin
            miscompares++;
            $display("FAIL byte_isolation ReadDataW=%h expected 7ffcd", ReadDataW);
        end
    endtask

    task automatic test_read_during_write();
        drive(1'b0, 1'b1, 1'b1, 5'd0, 19'h00055, 19'h20, 1'b0);
        applyEdge();
        vectors++;
        if (ReadDataW !== 19'h00000) begin
            miscompares++;
            $display("FAIL rdw_old ReadDataW=%h expected 00000", ReadDataW);
        end
        drive(1'b0, 1'b0, 1'b1, 5'd0, 19'd0, 19'h20, 1'b0);
        applyEdge();
        vectors++;
        if (ReadDataW !== 19'h00055) begin
            miscompares++;
            $display("FAIL rdw_new ReadDataW=%h expected 00055", ReadDataW);
        end
    endtask

    task automatic test_pass_through();
        drive(1'b1, 1'b0, 1'b0, 5'd9, 19'd0, 19'h12345, 1'b0);
        applyEdge();
        vectors++;
        if (RegWriteW !== 1'b1 || RDW !== 5'd9 || ResultSrcW !== 1'b0) begin
            miscompares++;
            $display("FAIL pass_ctrl RegWriteW=%b RDW=%0d ResultSrcW=%b expected 1 9 0", RegWriteW, RDW, ResultSrcW);
        end
        vectors++;
        if (ResultW !== 19'h12345) begin
            miscompares++;
            $display("FAIL pass_result ResultW=%h expected 12345", ResultW);
        end
    endtask

    task automatic test_wrap();
        // Word at the last byte address wraps (or is dropped with range checking).
        drive(1'b0, 1'b1, 1'b0, 5'd0, 19'h5A1B2, 19'h3FF, 1'b1);
        applyEdge();
        drive(1'b0, 1'b0, 1'b1, 5'd0, 19'd0, 19'h3FF, 1'b1);
        applyEdge();
        vectors++;
        if (ReadDataW !== expReadW) begin
            miscompares++;
            $display("FAIL wrap_word ReadDataW=%h expected %h", ReadDataW, expReadW);
        end
        drive(1'b0, 1'b0, 1'b1, 5'd0, 19'd0, 19'h400, 1'b0);
        applyEdge();
        vectors++;
        if (ReadDataW !== expReadW) begin
            miscompares++;
            $display("FAIL alias_byte ReadDataW=%h expected %h", ReadDataW, expReadW);
        end
    endtask

    task automatic test_random();
        logic [18:0] addr;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       addr = 19'($urandom);
                1:       addr = 19'(DEPTH - 4 + $urandom_range(0, 6));
                2:       addr = 19'($urandom_range(0, 63));
                default: addr = 19'($urandom_range(0, 7) * DEPTH + $urandom_range(DEPTH - 3, DEPTH - 1));
            endcase
            drive(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 19'($urandom), addr, 1'($urandom));
            applyEdge();
            vectors++;
            if (RegWriteW !== expRegW || ResultSrcW !== expSrcW || RDW !== expRdW) begin
                miscompares++;
                $display("FAIL rand_ctrl i=%0d got %b %b %0d expected %b %b %0d",
                         i, RegWriteW, ResultSrcW, RDW, expRegW, expSrcW, expRdW);
            end
            vectors++;
            if (ReadDataW !== expReadW) begin
                miscompares++;
                $display("FAIL rand_read i=%0d ReadDataW=%h expected %h", i, ReadDataW, expReadW);
            end
            vectors++;
            if (ResultW !== expResultW) begin
                miscompares++;
                $display("FAIL rand_result i=%0d ResultW=%h expected %h", i, ResultW, expResultW);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) refMem[i] = 8'd0;
        clearModelRegs();
        test_reset();
        test_byte_store_load();
        test_word_store_load();
        test_byte_isolation();
        test_read_during_write();
        test_pass_through();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
